// File: rtl/fpga_rst_seq_if.sv
// rtl/fpga_rst_seq_if.sv - pad-side signal bundle of the board reset sequencer
//
// Groups the three asynchronous reset sources and the sequenced outputs.
//   io_rst_ni     raw push-button pad, active-low, bouncy
//   pll_locked_i  PLL lock indication, asynchronous to the sequencer clock
//   jtag_srst_ni  JTAG system reset request, active-low
//   rst_no        sequenced core reset, active-low, registered
//   running_o     high while the sequencer is in RUN
//   rst_cause_o   sticky {jtag, pll, button} cause (FPGA_RST_SEQ_CAUSE_EN only)
// Modports: master = board/pad side, slave = sequencer.

interface fpga_rst_seq_if;
    logic       io_rst_ni;
    logic       pll_locked_i;
    logic       jtag_srst_ni;
    logic       rst_no;
    logic       running_o;
`ifdef FPGA_RST_SEQ_CAUSE_EN
    logic [2:0] rst_cause_o;
`endif

`ifdef FPGA_RST_SEQ_CAUSE_EN
    modport master (
        output io_rst_ni, pll_locked_i, jtag_srst_ni,
        input  rst_no, running_o, rst_cause_o
    );
    modport slave (
        input  io_rst_ni, pll_locked_i, jtag_srst_ni,
        output rst_no, running_o, rst_cause_o
    );
`else
    modport master (
        output io_rst_ni, pll_locked_i, jtag_srst_ni,
        input  rst_no, running_o
    );
    modport slave (
        input  io_rst_ni, pll_locked_i, jtag_srst_ni,
        output rst_no, running_o
    );
`endif
endinterface

// File: rtl/fpga_rst_seq.sv
// rtl/fpga_rst_seq.sv - board reset sequencer: sync, debounce, stretch, sticky cause
//
// Ports:
//   clk_i  free-running board clock (independent of the PLL)
//   rst_i  asynchronous active-high reset
//   pads   fpga_rst_seq_if.slave: io_rst_ni, pll_locked_i, jtag_srst_ni in;
//          rst_no, running_o (and rst_cause_o) out
// Optional feature macro: FPGA_RST_SEQ_CAUSE_EN adds the sticky reset-cause
// register rst_cause_o = {jtag, pll, button}, loaded on every RUN->WAIT exit.

module fpga_rst_seq #(
    parameter int SyncStages     = 2,
    parameter int DebounceCycles = 10000,
    parameter int StretchCycles  = 64,
    parameter int CntW           = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fpga_rst_seq_if.slave pads
);

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    logic [SyncStages-1:0] btn_sync_q;
    logic [SyncStages-1:0] pll_sync_q;
    logic [SyncStages-1:0] jtag_sync_q;
    logic                  btn_sync;
    logic                  pll_sync;
    logic                  jtag_sync;

    logic                  btn_deb_q;
    logic [CntW-1:0]       deb_cnt_q;

    state_t                state_q;
    state_t                state_next;
    logic [CntW-1:0]       stretch_cnt_q;
    logic [CntW-1:0]       stretch_cnt_next;
    logic                  src_ok;
    logic                  rst_n_q;
    logic                  running_q;

    // Synchronizer chains; the MSB is the synchronized value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_sync_q  <= '0;
            pll_sync_q  <= '0;
            jtag_sync_q <= '0;
        end else begin
            btn_sync_q  <= {btn_sync_q[SyncStages-2:0],  pads.io_rst_ni};
            pll_sync_q  <= {pll_sync_q[SyncStages-2:0],  pads.pll_locked_i};
            jtag_sync_q <= {jtag_sync_q[SyncStages-2:0], pads.jtag_srst_ni};
        end
    end

    assign btn_sync  = btn_sync_q[SyncStages-1];
    assign pll_sync  = pll_sync_q[SyncStages-1];
    assign jtag_sync = jtag_sync_q[SyncStages-1];

    // Button debounce: the DebounceCycles-th consecutive differing sample
    // flips the debounced level, so a held level lands exactly DebounceCycles
    // cycles after it leaves the synchronizer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_deb_q <= 1'b0;
            deb_cnt_q <= '0;
        end else if (btn_sync == btn_deb_q) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q == CntW'(DebounceCycles - 1)) begin
            btn_deb_q <= btn_sync;
            deb_cnt_q <= '0;
        end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
        end
    end

    // PLL lock and JTAG request are taken undebounced: one low sample counts.
    assign src_ok = btn_deb_q & pll_sync & jtag_sync;

    always_comb begin
        state_next       = state_q;
        stretch_cnt_next = '0;
        case (state_q)
            ST_WAIT: begin
                if (src_ok) begin
                    state_next = ST_STRETCH;
                end
            end
            ST_STRETCH: begin
                // A source dropping on the final stretch cycle wins over RUN.
                if (!src_ok) begin
                    state_next = ST_WAIT;
                end else if (stretch_cnt_q == CntW'(StretchCycles - 1)) begin
                    state_next = ST_RUN;
                end else begin
                    stretch_cnt_next = stretch_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!src_ok) begin
                    state_next = ST_WAIT;
                end
            end
            default: begin
                state_next = ST_WAIT;
            end
        endcase
    end

    // Outputs are registered from the next state so rst_no is glitch-free
    // and high exactly on cycles where the state register holds RUN.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_WAIT;
            stretch_cnt_q <= '0;
            rst_n_q       <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_next;
            stretch_cnt_q <= stretch_cnt_next;
            rst_n_q       <= (state_next == ST_RUN);
            running_q     <= (state_next == ST_RUN);
        end
    end

    assign pads.rst_no    = rst_n_q;
    assign pads.running_o = running_q;

`ifdef FPGA_RST_SEQ_CAUSE_EN
    logic [2:0] cause_q;

    // Only a RUN exit records a cause; aborted stretches leave it untouched.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cause_q <= 3'b000;
        end else if (state_q == ST_RUN && state_next == ST_WAIT) begin
            cause_q <= {~jtag_sync, ~pll_sync, ~btn_deb_q};
        end
    end

    assign pads.rst_cause_o = cause_q;
`endif

endmodule

// File: tb/tb_fpga_rst_seq.sv
// tb/tb_fpga_rst_seq.sv - directed self-checking bench for fpga_rst_seq

module tb_fpga_rst_seq;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    fpga_rst_seq_if bus ();

    fpga_rst_seq #(
        .SyncStages     (2),
        .DebounceCycles (8),
        .StretchCycles  (4),
        .CntW           (16)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .pads  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle, so inputs driven afterwards are
    // sampled at the following edge and outputs are read away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_cause(input string tag, input logic [2:0] exp);
`ifdef FPGA_RST_SEQ_CAUSE_EN
        chk(tag, bus.rst_cause_o, exp);
`else
        chk(tag, {2'b00, bus.rst_no | ~bus.rst_no}, 3'b001);
`endif
    endtask

    // From reset release: 2 sync + 8 debounce + 1 WAIT + 4 STRETCH = 15 edges.
    task automatic powerup(input string tag);
        for (int i = 1; i <= 14; i++) begin
            tick();
            chk({tag, "_low"}, {2'b00, bus.rst_no}, 3'b000);
        end
        tick();
        chk({tag, "_rise"}, {2'b00, bus.rst_no}, 3'b001);
        chk({tag, "_running"}, {2'b00, bus.running_o}, 3'b001);
        chk_cause({tag, "_cause"}, 3'b000);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.io_rst_ni    = 1'b1;
        bus.pll_locked_i = 1'b1;
        bus.jtag_srst_ni = 1'b1;

        tick();
        tick();
        chk("reset_rst_no", {2'b00, bus.rst_no}, 3'b000);
        chk("reset_running", {2'b00, bus.running_o}, 3'b000);
        chk_cause("reset_cause", 3'b000);
        rst = 1'b0;

        powerup("powerup");

        // Button bounce shorter than the debounce window is ignored.
        bus.io_rst_ni = 1'b0;
        repeat (5) tick();
        bus.io_rst_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bounce_hold", {2'b00, bus.rst_no}, 3'b001);
        end

        // Held press: falls on the 11th edge after the pad goes low.
        bus.io_rst_ni = 1'b0;
        repeat (10) tick();
        chk("press_edge10", {2'b00, bus.rst_no}, 3'b001);
        tick();
        chk("press_edge11", {2'b00, bus.rst_no}, 3'b000);
        chk("press_running", {2'b00, bus.running_o}, 3'b000);
        chk_cause("press_cause", 3'b001);
        repeat (9) tick();
        bus.io_rst_ni = 1'b1;
        repeat (14) tick();
        chk("release_edge14", {2'b00, bus.rst_no}, 3'b000);
        tick();
        chk("release_edge15", {2'b00, bus.rst_no}, 3'b001);
        chk_cause("release_cause", 3'b001);

        // One-cycle JTAG request.
        bus.jtag_srst_ni = 1'b0;
        tick();
        bus.jtag_srst_ni = 1'b1;
        tick();
        chk("jtag_edge1", {2'b00, bus.rst_no}, 3'b001);
        tick();
        chk("jtag_edge2", {2'b00, bus.rst_no}, 3'b000);
        chk_cause("jtag_cause", 3'b100);
        for (int i = 3; i <= 6; i++) begin
            tick();
            chk("jtag_low", {2'b00, bus.rst_no}, 3'b000);
        end
        tick();
        chk("jtag_rerise", {2'b00, bus.rst_no}, 3'b001);

        // PLL glitch landing on stretch count 2 aborts the stretch.
        bus.jtag_srst_ni = 1'b0;
        tick();
        bus.jtag_srst_ni = 1'b1;
        tick();
        tick();
        tick();
        bus.pll_locked_i = 1'b0;
        tick();
        bus.pll_locked_i = 1'b1;
        for (int i = 5; i <= 10; i++) begin
            tick();
            chk("pll_stretch_low", {2'b00, bus.rst_no}, 3'b000);
            chk("pll_stretch_run", {2'b00, bus.running_o}, 3'b000);
        end
        tick();
        chk("pll_stretch_rise", {2'b00, bus.rst_no}, 3'b001);
        chk_cause("pll_stretch_cause", 3'b100);

        // JTAG and PLL dropping together in RUN.
        bus.jtag_srst_ni = 1'b0;
        bus.pll_locked_i = 1'b0;
        tick();
        bus.jtag_srst_ni = 1'b1;
        bus.pll_locked_i = 1'b1;
        tick();
        chk("simul_edge1", {2'b00, bus.rst_no}, 3'b001);
        tick();
        chk("simul_edge2", {2'b00, bus.rst_no}, 3'b000);
        chk_cause("simul_cause", 3'b110);
        repeat (4) tick();
        chk("simul_low", {2'b00, bus.rst_no}, 3'b000);
        tick();
        chk("simul_rise", {2'b00, bus.rst_no}, 3'b001);

        // Sub-cycle asynchronous reset pulse mid-RUN.
        rst = 1'b1;
        #2;
        chk("async_rst_no", {2'b00, bus.rst_no}, 3'b000);
        chk("async_running", {2'b00, bus.running_o}, 3'b000);
        chk_cause("async_cause", 3'b000);
        #1;
        rst = 1'b0;
        powerup("repower");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
